// File: rtl/spart_pkg.sv
// rtl/spart_pkg.sv - SPART bus addresses, baud divisors and scheduler states
package spart_pkg;

   localparam logic [1:0] ADDR_BUF  = 2'b00;
   localparam logic [1:0] ADDR_STAT = 2'b01;
   localparam logic [1:0] ADDR_DBL  = 2'b10;
   localparam logic [1:0] ADDR_DBH  = 2'b11;

   localparam logic [1:0] BR_325 = 2'b00;
   localparam logic [1:0] BR_162 = 2'b01;
   localparam logic [1:0] BR_81  = 2'b10;
   localparam logic [1:0] BR_40  = 2'b11;

   localparam logic [7:0] DIV325_LO = 8'h45;
   localparam logic [7:0] DIV325_HI = 8'h01;
   localparam logic [7:0] DIV162_LO = 8'hA2;
   localparam logic [7:0] DIV162_HI = 8'h00;
   localparam logic [7:0] DIV81_LO  = 8'h51;
   localparam logic [7:0] DIV81_HI  = 8'h00;
   localparam logic [7:0] DIV40_LO  = 8'h28;
   localparam logic [7:0] DIV40_HI  = 8'h00;

   typedef enum logic [2:0] {
      CFG_LO,
      CFG_HI,
      IDLE,
      READ,
      WRITE,
      GAP
   } sched_state_t;

   // {high, low} divisor bytes for a baud select code
   function automatic logic [15:0] divisor(input logic [1:0] cfg);
      logic [15:0] d;
      case (cfg)
         BR_325:  d = {DIV325_HI, DIV325_LO};
         BR_162:  d = {DIV162_HI, DIV162_LO};
         BR_81:   d = {DIV81_HI, DIV81_LO};
         default: d = {DIV40_HI, DIV40_LO};
      endcase
      return d;
   endfunction

endpackage

// File: rtl/spart_byte_fifo.sv
// rtl/spart_byte_fifo.sv - byte FIFO with combinational head, used as the echo buffer
module spart_byte_fifo #(
   parameter int DEPTH = 4,
   parameter int CNT_W = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic             pop,
   input  logic [7:0]       din,
   output logic [7:0]       dout,
   output logic             full,
   output logic             empty,
   output logic [CNT_W-1:0] count
);

   localparam int PTR_W = $clog2(DEPTH);

   logic [7:0]       mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             push_ok;
   logic             pop_ok;

   assign full    = (count == CNT_W'(DEPTH));
   assign empty   = (count == '0);
   assign push_ok = push && !full;
   assign pop_ok  = pop && !empty;
   assign dout    = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (push_ok)
         mem[wr_ptr] <= din;
   end

   // pointers are PTR_W wide so they wrap modulo DEPTH on their own
   always_ff @(posedge clk) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_ok)
            wr_ptr <= wr_ptr + 1'b1;
         if (pop_ok)
            rd_ptr <= rd_ptr + 1'b1;
         case ({push_ok, pop_ok})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/spart_bus_sched.sv
// rtl/spart_bus_sched.sv - SPART bus master: programs the baud divisor, then echoes RX bytes to TX
module spart_bus_sched
   import spart_pkg::*;
#(
   parameter int FIFO_DEPTH = 4,
   parameter int CNT_W      = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [1:0]       br_cfg,
   input  logic             rda,
   input  logic             tbr,
   output logic             iocs,
   output logic             iorw,
   output logic [1:0]       ioaddr,
   inout  wire  [7:0]       databus,
   output logic             cfg_done,
   output logic [CNT_W-1:0] fifo_count
);

   sched_state_t state;
   sched_state_t nxt;
   logic         boot;
   logic [1:0]   cfg_q;
   logic [1:0]   cfg_n;
   logic         reconf;
   logic [15:0]  div;
   logic         drv_en;
   logic [7:0]   drv_data;
   logic         push;
   logic         pop;
   logic         full;
   logic         empty;
   logic [7:0]   head;

   assign push    = (state == READ);
   assign pop     = (state == WRITE);
   assign div     = divisor(cfg_n);
   assign databus = drv_en ? drv_data : 8'bz;

   spart_byte_fifo #(
      .DEPTH (FIFO_DEPTH),
      .CNT_W (CNT_W)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .pop   (pop),
      .din   (databus),
      .dout  (head),
      .full  (full),
      .empty (empty),
      .count (fifo_count)
   );

   // boot marks the idle cycle after reset; CFG_LO is then issued without advancing
   always_comb begin
      nxt    = state;
      cfg_n  = cfg_q;
      reconf = 1'b0;
      if (boot) begin
         nxt = CFG_LO;
      end else begin
         case (state)
            CFG_LO:             nxt = CFG_HI;
            CFG_HI, READ, WRITE: nxt = GAP;
            GAP:                nxt = IDLE;
            IDLE: begin
               if (br_cfg != cfg_q) begin
                  reconf = 1'b1;
                  cfg_n  = br_cfg;
                  nxt    = CFG_LO;
               end else if (rda && !full) begin
                  nxt = READ;
               end else if (tbr && !empty) begin
                  nxt = WRITE;
               end else begin
                  nxt = IDLE;
               end
            end
            default:            nxt = IDLE;
         endcase
      end
   end

   // bus outputs are decoded from the state being entered so they line up with it
   always_ff @(posedge clk) begin
      if (!rst) begin
         state    <= CFG_LO;
         boot     <= 1'b1;
         cfg_q    <= br_cfg;
         cfg_done <= 1'b0;
         iocs     <= 1'b0;
         iorw     <= 1'b1;
         ioaddr   <= ADDR_BUF;
         drv_en   <= 1'b0;
         drv_data <= 8'h00;
      end else begin
         boot  <= 1'b0;
         state <= nxt;
         cfg_q <= cfg_n;
         if (reconf)
            cfg_done <= 1'b0;
         else if (state == CFG_HI)
            cfg_done <= 1'b1;
         case (nxt)
            CFG_LO: begin
               iocs     <= 1'b1;
               iorw     <= 1'b0;
               ioaddr   <= ADDR_DBL;
               drv_en   <= 1'b1;
               drv_data <= div[7:0];
            end
            CFG_HI: begin
               iocs     <= 1'b1;
               iorw     <= 1'b0;
               ioaddr   <= ADDR_DBH;
               drv_en   <= 1'b1;
               drv_data <= div[15:8];
            end
            READ: begin
               iocs     <= 1'b1;
               iorw     <= 1'b1;
               ioaddr   <= ADDR_BUF;
               drv_en   <= 1'b0;
            end
            WRITE: begin
               iocs     <= 1'b1;
               iorw     <= 1'b0;
               ioaddr   <= ADDR_BUF;
               drv_en   <= 1'b1;
               drv_data <= head;
            end
            default: begin
               iocs     <= 1'b0;
               iorw     <= 1'b1;
               ioaddr   <= ADDR_BUF;
               drv_en   <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_spart_bus_sched.sv
// tb/tb_spart_bus_sched.sv - cycle-by-cycle check of spart_bus_sched against a bus-rule model
module tb_spart_bus_sched;

   localparam int DEPTH = 4;
   localparam int K_IDLE = 0;
   localparam int K_LO   = 1;
   localparam int K_HI   = 2;
   localparam int K_RD   = 3;
   localparam int K_WR   = 4;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [1:0] br_cfg = 2'b00;
   logic       rda = 1'b0;
   logic       tbr = 1'b0;
   logic       iocs;
   logic       iorw;
   logic [1:0] ioaddr;
   wire  [7:0] databus;
   logic       cfg_done;
   logic [2:0] fifo_count;
   logic [7:0] rx_byte = 8'h00;
   bit         rx_inc = 1'b0;

   int errors = 0;
   int checks = 0;

   logic [7:0] q[$];
   logic [1:0] m_cfg;
   bit         m_done;
   bit         after_rst;
   int         cur_k;
   int         prev_k;

   spart_bus_sched #(.FIFO_DEPTH(DEPTH), .CNT_W(3)) dut (
      .clk        (clk),
      .rst        (rst),
      .br_cfg     (br_cfg),
      .rda        (rda),
      .tbr        (tbr),
      .iocs       (iocs),
      .iorw       (iorw),
      .ioaddr     (ioaddr),
      .databus    (databus),
      .cfg_done   (cfg_done),
      .fifo_count (fifo_count)
   );

   // the SPART drives the bus only while it is being read
   assign databus = (iocs && iorw) ? rx_byte : 8'bz;

   always #5 clk = ~clk;

   function automatic logic [7:0] div_byte(input logic [1:0] c, input bit hi);
      int d;
      case (c)
         2'd0:    d = 325;
         2'd1:    d = 162;
         2'd2:    d = 81;
         default: d = 40;
      endcase
      return hi ? 8'((d >> 8) & 255) : 8'(d & 255);
   endfunction

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // check the current cycle, apply its effect to the model, predict the next cycle
   task automatic step();
      int  nk;
      bit  inc;
      inc = 1'b0;
      @(negedge clk);
      case (cur_k)
         K_LO: begin
            chk("lo_cs", iocs, 1); chk("lo_rw", iorw, 0); chk("lo_addr", ioaddr, 2);
            chk("lo_data", databus, div_byte(m_cfg, 0));
         end
         K_HI: begin
            chk("hi_cs", iocs, 1); chk("hi_rw", iorw, 0); chk("hi_addr", ioaddr, 3);
            chk("hi_data", databus, div_byte(m_cfg, 1));
         end
         K_RD: begin
            chk("rd_cs", iocs, 1); chk("rd_rw", iorw, 1); chk("rd_addr", ioaddr, 0);
            chk("rd_data", databus, rx_byte);
         end
         K_WR: begin
            chk("wr_cs", iocs, 1); chk("wr_rw", iorw, 0); chk("wr_addr", ioaddr, 0);
            chk("wr_data", databus, (q.size() > 0) ? q[0] : 8'hxx);
         end
         default: begin
            chk("idle_cs", iocs, 0); chk("idle_rw", iorw, 1); chk("idle_addr", ioaddr, 0);
            chk("idle_data", databus, 8'bz);
         end
      endcase
      chk("cfg_done", cfg_done, m_done);
      chk("fifo_count", fifo_count, 8'(q.size()));

      case (cur_k)
         K_RD: begin q.push_back(rx_byte); inc = rx_inc; end
         K_WR: if (q.size() > 0) void'(q.pop_front());
         K_HI: m_done = 1'b1;
         default: ;
      endcase

      if (!rst) begin
         q.delete();
         m_cfg     = br_cfg;
         m_done    = 1'b0;
         after_rst = 1'b1;
         nk        = K_IDLE;
      end else if (after_rst) begin
         after_rst = 1'b0;
         nk        = K_LO;
      end else if (cur_k == K_LO) begin
         nk = K_HI;
      end else if (cur_k != K_IDLE || prev_k != K_IDLE) begin
         nk = K_IDLE;
      end else if (br_cfg != m_cfg) begin
         m_cfg  = br_cfg;
         m_done = 1'b0;
         nk     = K_LO;
      end else if (rda && q.size() < DEPTH) begin
         nk = K_RD;
      end else if (tbr && q.size() > 0) begin
         nk = K_WR;
      end else begin
         nk = K_IDLE;
      end
      prev_k = cur_k;
      cur_k  = nk;

      @(posedge clk);
      #1;
      if (inc) rx_byte = rx_byte + 8'd1;
   endtask

   task automatic run_until(input int kind, input int max_cycles);
      for (int i = 0; i < max_cycles && cur_k != kind; i++)
         step();
   endtask

   initial begin
      repeat (2) @(posedge clk);
      #1;
      q.delete();
      m_cfg     = br_cfg;
      m_done    = 1'b0;
      after_rst = 1'b1;
      cur_k     = K_IDLE;
      prev_k    = K_IDLE;
      rst       = 1'b1;

      repeat (5) step();

      br_cfg = 2'b01;
      repeat (6) step();

      rx_byte = 8'h3C;
      rda = 1'b1;
      run_until(K_RD, 10);
      rda = 1'b0;
      repeat (4) step();
      tbr = 1'b1;
      run_until(K_WR, 10);
      tbr = 1'b0;
      repeat (4) step();

      rx_byte = 8'h11;
      rx_inc  = 1'b1;
      rda     = 1'b1;
      repeat (30) step();
      rda = 1'b0;
      chk("fill_stop", fifo_count, 8'd4);
      tbr = 1'b1;
      repeat (20) step();
      tbr = 1'b0;

      rda = 1'b1;
      tbr = 1'b1;
      repeat (40) step();
      rx_inc = 1'b0;

      for (int i = 0; i < 300; i++) begin
         rda     = 1'($urandom_range(0, 1));
         tbr     = 1'($urandom_range(0, 1));
         rx_byte = 8'($urandom);
         if ($urandom_range(0, 24) == 0)
            br_cfg = 2'($urandom);
         step();
      end

      rda = 1'b1;
      tbr = 1'b0;
      repeat (20) step();
      rda = 1'b0;
      tbr = 1'b1;
      run_until(K_WR, 10);
      rst = 1'b0;
      step();
      rst = 1'b1;
      tbr = 1'b0;
      repeat (6) step();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
